ibex_pext_encoder: RTL and testbench
====================================

# ibex_pext_encoder

Sequential instruction encoder for the Zpn (P-extension) custom-opcode space. It turns field-level operation requests into 32-bit instruction words in the format the Zpn decoder consumes: opcode 7'h77, funct3/funct7 major/minor select, rs2/imm5/subf5 field. It can expand one request into a sweep over the rs2 field, and it buffers results in a small FIFO behind a valid/ready handshake. It is used as an instruction-stream source for core-level directed tests and for fetch-side stimulus injection.

## Interface

- CntWidth, 16, width of the emitted-instruction counter.
- Depth, 2, output FIFO entries; power of two, ≥2.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  request accepted when high together with req_valid_i.
- req_funct3_i  input  3  major group; only 3'b000, 3'b001 and 3'b010 are legal.
- req_funct7_i  input  7  minor op select.
- req_rs2_i  input  5  rs2/imm5/subf5 field; in sweep mode, the inclusive sweep upper limit.
- req_rs1_i  input  5  rs1 field.
- req_rd_i  input  5  rd field.
- req_sweep_i  input  1  expand the request over rs2 = 0..req_rs2_i.
- instr_valid_o  output  1  FIFO head valid.
- instr_o  output  32  FIFO head word.
- instr_ready_i  input  1  consumer takes the head.
- err_o  output  1  one-cycle pulse: an illegal request was consumed.
- instr_cnt_o  output  CntWidth  saturating count of emitted words.

## Operation

- Word format: {funct7, rs2, rs1, funct3, rd, 7'h77}. funct7 and rs1 pass through unchecked.
- Legality: funct3 ∈ {000, 001, 010}. An illegal request is still accepted, but no word is queued, there is no sweep, and err_o pulses.
- FSM states:
  - IDLE: req_ready_o = (fifo_count < Depth).
    - Accepted legal request with req_sweep_i = 0: push the word in the same cycle; stay in IDLE.
    - Accepted legal request with req_sweep_i = 1: latch funct7/funct3/rs1/rd and the limit, set sweep_idx = 0, go to SWEEP. Nothing is pushed in the accept cycle.
  - SWEEP: req_ready_o = 0.
    - Each cycle with fifo_count < Depth at cycle start: push the word with rs2 = sweep_idx.
    - sweep_idx increments after each push.
    - When the pushed sweep_idx equals the limit, return to IDLE.
    - Limit 0 emits exactly one word. Limit 31 emits 32 words; sweep_idx is 5 bits and the termination compare uses the pre-increment value, so wrap-around does not matter.
- FIFO: in-order. instr_o/instr_valid_o reflect the head. Pop when instr_valid_o && instr_ready_i.
  - Simultaneous push and pop when full is not possible, because ready and push space are computed from the start-of-cycle count.
  - When not full, simultaneous push and pop leaves the count unchanged.
- req_ready_o has no combinational dependence on instr_ready_i or on the req_* inputs.
- instr_cnt_o: +1 per pop; saturates at all-ones.
- Reset (asynchronous, any state, including mid-sweep): FSM → IDLE, FIFO emptied, sweep_idx = 0.
  - instr_valid_o = 0, instr_o = 0, err_o = 0, instr_cnt_o = 0.
  - req_ready_o = 1 while in reset, since IDLE with an empty FIFO.

## Timing

- Non-sweep accept in cycle N → instr_valid_o high in N+1, provided earlier entries are drained.
- Sweep accept in N → first word pushed in N+1, visible in N+2; one word per cycle after that while instr_ready_i = 1.
- Sustained throughput: 1 word/cycle with instr_ready_i held high.
- err_o: registered; high exactly in cycle N+1 for an illegal accept in N.
- instr_cnt_o: updates the cycle after the pop.
- With the default Depth of 2, back-to-back non-sweep requests stall only when 2 entries are outstanding.

## Test plan

- Single ADD16: funct3 = 0, funct7 = 7'h20, rs2 = 3, rs1 = 2, rd = 1, sweep = 0, instr_ready_i = 1.
  → instr_o = 32'h403100F7, valid one cycle after accept; instr_cnt_o = 1.
- Illegal: funct3 = 3'b011.
  → err_o high for exactly one cycle (N+1); instr_valid_o stays 0; instr_cnt_o unchanged; req_ready_o stays 1.
- Sweep SRAI16: funct3 = 0, funct7 = 7'h38, rs2 limit = 15, rs1 = 5, rd = 6, ready held high.
  → 16 consecutive words 32'h70028377 + (i<<20) for i = 0..15; first word at N+2; req_ready_o = 0 until the last push; instr_cnt_o = 16.
- Backpressure: instr_ready_i = 0, three back-to-back legal non-sweep requests A, B, C.
  → A and B accepted; req_ready_o = 0 and C held.
  → Raise ready: A then B pop; C is accepted at the first cycle with free space; output order is A, B, C.
- Reset mid-sweep: assert rst_ni = 0 after 7 sweep words have been pushed.
  → Immediately: instr_valid_o = 0, instr_cnt_o = 0, err_o = 0, req_ready_o = 1.
  → After release: a fresh non-sweep request behaves as in the single ADD16 scenario.
- Saturation: CntWidth = 4, 20 pops.
  → instr_cnt_o reaches 4'hF and holds.

Source files
------------

// File: rtl/ibex_pext_encoder.sv
// ibex_pext_encoder
// Turns field-level Zpn operation requests into 32-bit instruction words
// {funct7, rs2, rs1, funct3, rd, 7'h77}. A request can be expanded into a
// sweep over rs2 = 0..limit. Words are queued in a small FIFO behind a
// valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   req_valid_i / req_ready_o  request handshake
//   req_funct3_i..req_rd_i     instruction fields (rs2 = sweep limit in sweep mode)
//   req_sweep_i                expand request over rs2
//   instr_valid_o / instr_o    FIFO head
//   instr_ready_i              consumer takes the head
//   err_o                      one-cycle pulse for a consumed illegal request
//   instr_cnt_o                saturating count of popped words
module ibex_pext_encoder #(
    parameter int CntWidth = 16,
    parameter int Depth    = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [2:0]          req_funct3_i,
    input  logic [6:0]          req_funct7_i,
    input  logic [4:0]          req_rs2_i,
    input  logic [4:0]          req_rs1_i,
    input  logic [4:0]          req_rd_i,
    input  logic                req_sweep_i,
    output logic                instr_valid_o,
    output logic [31:0]         instr_o,
    input  logic                instr_ready_i,
    output logic                err_o,
    output logic [CntWidth-1:0] instr_cnt_o
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] DEPTH_L = Depth[AW:0];

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e                r_state, w_state_nxt;
    logic [Depth-1:0][31:0] r_mem;
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [AW:0]           r_count;
    logic [6:0]            r_f7;
    logic [2:0]            r_f3;
    logic [4:0]            r_rs1, r_rd, r_lim, r_idx;
    logic                  r_err;
    logic [CntWidth-1:0]   r_cnt;

    logic        w_full, w_empty, w_legal, w_acc, w_push, w_pop, w_latch;
    logic [31:0] w_word;

    // All flow control uses the start-of-cycle count, so a push is never
    // attempted into a full FIFO and req_ready_o is independent of the
    // consumer side and of the request inputs.
    assign w_full      = (r_count == DEPTH_L);
    assign w_empty     = (r_count == '0);
    assign w_legal     = (req_funct3_i < 3'd3);
    assign req_ready_o = (r_state == IDLE) && !w_full;
    assign w_acc       = req_valid_i && req_ready_o;
    assign w_pop       = !w_empty && instr_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_latch     = 1'b0;
        w_word      = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, 7'h77};
        case (r_state)
            IDLE: begin
                if (w_acc && w_legal) begin
                    if (req_sweep_i) begin
                        w_latch     = 1'b1;
                        w_state_nxt = SWEEP;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            SWEEP: begin
                w_word = {r_f7, r_idx, r_rs1, r_f3, r_rd, 7'h77};
                if (!w_full) begin
                    w_push = 1'b1;
                    // Compare pre-increment index so limit 31 terminates
                    // before the 5-bit index wraps.
                    if (r_idx == r_lim) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_f7    <= '0;
            r_f3    <= '0;
            r_rs1   <= '0;
            r_rd    <= '0;
            r_lim   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_acc && !w_legal;
            if (w_latch) begin
                r_f7  <= req_funct7_i;
                r_f3  <= req_funct3_i;
                r_rs1 <= req_rs1_i;
                r_rd  <= req_rd_i;
                r_lim <= req_rs2_i;
                r_idx <= '0;
            end else if (w_push && r_state == SWEEP) begin
                r_idx <= r_idx + 5'd1;
            end
            if (w_push) begin
                r_mem[r_wptr] <= w_word;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign instr_valid_o = !w_empty;
    assign instr_o       = w_empty ? 32'h0 : r_mem[r_rptr];
    assign err_o         = r_err;
    assign instr_cnt_o   = r_cnt;

endmodule

// File: tb/tb_ibex_pext_encoder.sv
module tb_ibex_pext_encoder;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [6:0]  req_funct7_i = '0;
    logic [4:0]  req_rs2_i = '0, req_rs1_i = '0, req_rd_i = '0;
    logic        req_sweep_i = 1'b0;
    logic        instr_ready_i = 1'b1;
    logic        req_ready_o, instr_valid_o, err_o;
    logic [31:0] instr_o;
    logic [15:0] instr_cnt_o;
    // second instance: same stimulus, 4-bit counter for saturation
    logic        s_ready, s_valid, s_err;
    logic [31:0] s_instr;
    logic [3:0]  s_cnt;

    int checks = 0, failures = 0;
    logic [31:0] exp_q[$];
    int mcnt = 0;
    logic err_pend = 1'b0;
    bit rnd_done = 1'b0;

    always #5 clk = ~clk;

    ibex_pext_encoder #(.CntWidth(16), .Depth(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct3_i(req_funct3_i), .req_funct7_i(req_funct7_i), .req_rs2_i(req_rs2_i),
        .req_rs1_i(req_rs1_i), .req_rd_i(req_rd_i), .req_sweep_i(req_sweep_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_ready_i(instr_ready_i),
        .err_o(err_o), .instr_cnt_o(instr_cnt_o));

    ibex_pext_encoder #(.CntWidth(4), .Depth(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(s_ready),
        .req_funct3_i(req_funct3_i), .req_funct7_i(req_funct7_i), .req_rs2_i(req_rs2_i),
        .req_rs1_i(req_rs1_i), .req_rd_i(req_rd_i), .req_sweep_i(req_sweep_i),
        .instr_valid_o(s_valid), .instr_o(s_instr), .instr_ready_i(instr_ready_i),
        .err_o(s_err), .instr_cnt_o(s_cnt));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int f3, input int f7, input int rs2,
                                       input int rs1, input int rd);
        return 32'(f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 'h77);
    endfunction

    // Monitor / scoreboard: compares every popped head against the queue,
    // and tracks err pulse and counter from observed handshakes.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            mcnt     = 0;
            err_pend = 1'b0;
        end else begin
            chk("cnt16", 32'(instr_cnt_o), 32'(mcnt));
            chk("cnt4_sat", 32'(s_cnt), (mcnt > 15) ? 32'd15 : 32'(mcnt));
            chk("err", 32'(err_o), 32'(err_pend));
            chk("twin_valid", 32'(s_valid), 32'(instr_valid_o));
            err_pend = req_valid_i && req_ready_o && (req_funct3_i > 3'd2);
            if (instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) chk("unexpected_word", instr_o, 32'hxxxxxxxx);
                else chk("word", instr_o, exp_q.pop_front());
                mcnt++;
            end
        end
    end

    // Call just after a posedge; returns just after the accepting posedge.
    task automatic send(input int f3, input int f7, input int rs2, input int rs1,
                        input int rd, input bit sw);
        bit ok = 1'b0;
        req_funct3_i = 3'(f3); req_funct7_i = 7'(f7); req_rs2_i = 5'(rs2);
        req_rs1_i = 5'(rs1); req_rd_i = 5'(rd); req_sweep_i = sw; req_valid_i = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (req_ready_o) begin ok = 1'b1; break; end
        end
        chk("accept_in_time", 32'(ok), 32'd1);
        if (ok) begin
            @(posedge clk);
            if (f3 < 3) begin
                if (sw) for (int i = 0; i <= rs2; i++) exp_q.push_back(mk(f3, f7, i, rs1, rd));
                else exp_q.push_back(mk(f3, f7, rs2, rs1, rd));
            end
        end
        #1 req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic add16_check();
        send(0, 'h20, 3, 2, 1, 1'b0);
        @(negedge clk);
        chk("add16_valid", 32'(instr_valid_o), 32'd1);
        chk("add16_word", instr_o, 32'h403100F7);
        @(negedge clk);
        chk("add16_cnt", 32'(instr_cnt_o), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cnt", 32'(instr_cnt_o), 32'd0);
        #20 rst_ni = 1'b1;
        @(posedge clk); #1;

        add16_check();

        // illegal funct3
        send(3, 'h20, 3, 2, 1, 1'b0);
        @(negedge clk);
        chk("ill_err", 32'(err_o), 32'd1);
        chk("ill_valid", 32'(instr_valid_o), 32'd0);
        chk("ill_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        chk("ill_err_clear", 32'(err_o), 32'd0);
        chk("ill_cnt", 32'(instr_cnt_o), 32'd1);
        @(posedge clk); #1;

        // sweep SRAI16, limit 15
        send(0, 'h38, 15, 5, 6, 1'b1);
        @(negedge clk);
        chk("sw_n1_valid", 32'(instr_valid_o), 32'd0);
        chk("sw_n1_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        chk("sw_n2_valid", 32'(instr_valid_o), 32'd1);
        chk("sw_n2_word", instr_o, 32'h70028377);
        drain();
        chk("sw_cnt", 32'(instr_cnt_o), 32'd17);

        // backpressure: A, B accepted, C held until space frees
        instr_ready_i = 1'b0;
        send(1, 'h01, 1, 1, 1, 1'b0);
        send(1, 'h02, 2, 2, 2, 1'b0);
        fork
            send(2, 'h03, 3, 3, 3, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_ready_low", 32'(req_ready_o), 32'd0);
                end
                @(posedge clk); #1 instr_ready_i = 1'b1;
            end
        join
        drain();

        // boundary sweep limits then random traffic with random backpressure
        send(1, 'h11, 0, 7, 8, 1'b1);
        send(2, 'h12, 31, 9, 10, 1'b1);
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int f3;
                    f3 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
                    send(f3, int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                         $urandom_range(0, 3) == 0);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1 instr_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        instr_ready_i = 1'b1;
        drain();
        chk("sat_hold", 32'(s_cnt), 32'hF);

        // reset mid-sweep
        send(0, 'h38, 20, 5, 6, 1'b1);
        repeat (7) @(posedge clk);
        #1 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("mid_rst_cnt", 32'(instr_cnt_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_ni = 1'b1;
        @(posedge clk); #1;
        add16_check();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
